// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared types, default constants and sensor decode for the lift shaft model
package lift_pkg;

  typedef enum logic [1:0] {
    STOPPED   = 2'd0,
    RUN_UP    = 2'd1,
    RUN_DOWN  = 2'd2,
    REVERSING = 2'd3
  } motion_t;

  // Board defaults, shared with the controller bench
  localparam int DEF_STEP_TICKS    = 5_000_000;
  localparam int DEF_POS_MAX       = 20;
  localparam int DEF_FLOOR1_POS    = 10;
  localparam int DEF_BAND          = 2;
  localparam int DEF_REVERSE_STEPS = 2;
  localparam int DEF_INIT_POS      = 5;

  // Active-low sensor vector, ordered {bottom, middle_minus, middle_plus, top}
  function automatic logic [3:0] sensor_decode(input int pos, input int pos_max,
                                               input int floor1, input int band);
    logic [3:0] s;
    s[3] = !(pos == 0);
    s[2] = !((pos >= floor1 - band) && (pos <= floor1));
    s[1] = !((pos >= floor1) && (pos <= floor1 + band));
    s[0] = !(pos == pos_max);
    return s;
  endfunction

endpackage

// File: rtl/lift_step_timer.sv
// rtl/lift_step_timer.sv - free-running step period counter with one-cycle wrap pulse
module lift_step_timer #(
  parameter int TICKS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic run_i,
  output logic step_o
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The wrap cycle is the step cycle; clear is resolved by the owner of the timer
  assign step_o = run_i && (cnt_q == LAST);

  // Next count: clear wins, otherwise count 0..TICKS-1 while running
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lift_shaft_model.sv
// rtl/lift_shaft_model.sv - lift car, motor and shaft sensor model driven by the controller
module lift_shaft_model
  import lift_pkg::*;
#(
  parameter int STEP_TICKS    = DEF_STEP_TICKS,
  parameter int POS_MAX       = DEF_POS_MAX,
  parameter int FLOOR1_POS    = DEF_FLOOR1_POS,
  parameter int BAND          = DEF_BAND,
  parameter int REVERSE_STEPS = DEF_REVERSE_STEPS,
  parameter int INIT_POS      = DEF_INIT_POS,
  parameter int POS_W         = $clog2(POS_MAX + 1)
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             direction,
  input  logic             enable,
  output logic             bottom,
  output logic             middle_minus,
  output logic             middle_plus,
  output logic             top,
  output logic [POS_W-1:0] position,
  output logic             moving,
  output logic             fault
);

  localparam int RW = (REVERSE_STEPS > 1) ? $clog2(REVERSE_STEPS) : 1;
  localparam logic [RW-1:0]    REV_LAST  = RW'(REVERSE_STEPS - 1);
  localparam logic [POS_W-1:0] INIT_P    = POS_W'(INIT_POS);
  localparam logic [POS_W-1:0] MAX_P     = POS_W'(POS_MAX);
  localparam logic [3:0]       SENS_INIT = sensor_decode(INIT_POS, POS_MAX, FLOOR1_POS, BAND);

  motion_t          state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [RW-1:0]    rev_q, rev_d;
  logic [3:0]       sens_q, sens_d;
  logic             fault_q, fault_d;
  logic             moving_q, moving_d;
  logic             timer_clear;
  logic             step;

  lift_step_timer #(.TICKS(STEP_TICKS)) u_timer (
    .clk_i   (clock),
    .rst_ni  (n_reset),
    .clear_i (timer_clear),
    .run_i   (state_q != STOPPED),
    .step_o  (step)
  );

  // Motion FSM: stop beats reversal beats a due step; endstops stall and latch fault
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    fault_d     = fault_q;
    rev_d       = '0;
    timer_clear = 1'b0;
    case (state_q)
      STOPPED: begin
        timer_clear = 1'b1;
        if (!enable) begin
          state_d = direction ? RUN_UP : RUN_DOWN;
        end
      end
      RUN_UP, RUN_DOWN: begin
        if (enable) begin
          state_d     = STOPPED;
          timer_clear = 1'b1;
        end else if (direction != (state_q == RUN_UP)) begin
          state_d     = REVERSING;
          timer_clear = 1'b1;
        end else if (step) begin
          if (state_q == RUN_UP) begin
            if (pos_q == MAX_P) fault_d = 1'b1;
            else                pos_d   = pos_q + POS_W'(1);
          end else begin
            if (pos_q == '0) fault_d = 1'b1;
            else             pos_d   = pos_q - POS_W'(1);
          end
        end
      end
      REVERSING: begin
        rev_d = rev_q;
        if (enable) begin
          state_d     = STOPPED;
          timer_clear = 1'b1;
          rev_d       = '0;
        end else if (step) begin
          if (rev_q == REV_LAST) begin
            // Direction is only looked at once the dead-time has fully elapsed
            state_d     = direction ? RUN_UP : RUN_DOWN;
            timer_clear = 1'b1;
            rev_d       = '0;
          end else begin
            rev_d = rev_q + RW'(1);
          end
        end
      end
      default: begin
        state_d     = STOPPED;
        timer_clear = 1'b1;
      end
    endcase
    moving_d = (state_d == RUN_UP) || (state_d == RUN_DOWN);
    sens_d   = sensor_decode(int'(pos_d), POS_MAX, FLOOR1_POS, BAND);
  end

  // State, position and registered output decodes
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= STOPPED;
      pos_q    <= INIT_P;
      rev_q    <= '0;
      fault_q  <= 1'b0;
      moving_q <= 1'b0;
      sens_q   <= SENS_INIT;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      rev_q    <= rev_d;
      fault_q  <= fault_d;
      moving_q <= moving_d;
      sens_q   <= sens_d;
    end
  end

  assign {bottom, middle_minus, middle_plus, top} = sens_q;
  assign position = pos_q;
  assign moving   = moving_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_lift_shaft_model.sv
// tb/tb_lift_shaft_model.sv - directed table-driven bench for lift_shaft_model
module tb_lift_shaft_model;

  logic       clock = 1'b0;
  logic       n_reset;
  logic       direction;
  logic       enable;
  logic       bottom, middle_minus, middle_plus, top;
  logic [3:0] position;
  logic       moving;
  logic       fault;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       en;
    logic       dir;
    int         cycles;
    int         pos;
    logic [3:0] sens;
    logic       mov;
    logic       flt;
  } vec_t;

  vec_t vecs[$];

  lift_shaft_model #(
    .STEP_TICKS    (4),
    .POS_MAX       (8),
    .FLOOR1_POS    (4),
    .BAND          (1),
    .REVERSE_STEPS (2),
    .INIT_POS      (2)
  ) dut (
    .clock        (clock),
    .n_reset      (n_reset),
    .direction    (direction),
    .enable       (enable),
    .bottom       (bottom),
    .middle_minus (middle_minus),
    .middle_plus  (middle_plus),
    .top          (top),
    .position     (position),
    .moving       (moving),
    .fault        (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int pos, input logic [3:0] sens,
                           input logic mov, input logic flt);
    check({tag, " position"}, 32'(position), 32'(pos));
    check({tag, " sensors"}, 32'({bottom, middle_minus, middle_plus, top}), 32'(sens));
    check({tag, " moving"}, 32'(moving), 32'(mov));
    check({tag, " fault"}, 32'(fault), 32'(flt));
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic add(input logic en, input logic dir, input int cycles, input int pos,
                     input logic [3:0] sens, input logic mov, input logic flt);
    vec_t v;
    v.en = en; v.dir = dir; v.cycles = cycles; v.pos = pos;
    v.sens = sens; v.mov = mov; v.flt = flt;
    vecs.push_back(v);
  endtask

  initial begin
    // Sensors {bottom, mid_minus, mid_plus, top}: idle and stable
    add(1, 0, 50, 2, 4'b1111, 0, 0);
    // Downward arrival at the bottom endstop, then stalls into a fault
    add(0, 0, 1, 2, 4'b1111, 1, 0);
    add(0, 0, 3, 2, 4'b1111, 1, 0);
    add(0, 0, 1, 1, 4'b1111, 1, 0);
    add(0, 0, 3, 1, 4'b1111, 1, 0);
    add(0, 0, 1, 0, 4'b0111, 1, 0);
    add(0, 0, 3, 0, 4'b0111, 1, 0);
    add(0, 0, 1, 0, 4'b0111, 1, 1);
    add(0, 0, 5, 0, 4'b0111, 1, 1);
    add(1, 0, 1, 0, 4'b0111, 0, 1);
    // Upward pass through floor 1
    add(0, 1, 1, 0, 4'b0111, 1, 1);
    add(0, 1, 4, 1, 4'b1111, 1, 1);
    add(0, 1, 4, 2, 4'b1111, 1, 1);
    add(0, 1, 3, 2, 4'b1111, 1, 1);
    add(0, 1, 1, 3, 4'b1011, 1, 1);
    add(0, 1, 4, 4, 4'b1001, 1, 1);
    add(0, 1, 4, 5, 4'b1101, 1, 1);
    add(0, 1, 4, 6, 4'b1111, 1, 1);
    // Stop with the counter at 2; restart needs a full step period
    add(0, 1, 2, 6, 4'b1111, 1, 1);
    add(1, 1, 1, 6, 4'b1111, 0, 1);
    add(1, 1, 3, 6, 4'b1111, 0, 1);
    add(0, 1, 1, 6, 4'b1111, 1, 1);
    add(0, 1, 3, 6, 4'b1111, 1, 1);
    add(0, 1, 1, 7, 4'b1111, 1, 1);
    // Reversal up->down: 8 dead cycles then 4 to the next step
    add(0, 0, 1, 7, 4'b1111, 0, 1);
    add(0, 0, 7, 7, 4'b1111, 0, 1);
    add(0, 0, 1, 7, 4'b1111, 1, 1);
    add(0, 0, 3, 7, 4'b1111, 1, 1);
    add(0, 0, 1, 6, 4'b1111, 1, 1);
    // Flip then flip back during dead-time resumes the original direction
    add(0, 1, 1, 6, 4'b1111, 0, 1);
    add(0, 0, 7, 6, 4'b1111, 0, 1);
    add(0, 0, 1, 6, 4'b1111, 1, 1);
    add(0, 0, 4, 5, 4'b1101, 1, 1);
    // Reverse to up and run into the top endstop
    add(0, 1, 1, 5, 4'b1101, 0, 1);
    add(0, 1, 8, 5, 4'b1101, 1, 1);
    add(0, 1, 4, 6, 4'b1111, 1, 1);
    add(0, 1, 4, 7, 4'b1111, 1, 1);
    add(0, 1, 4, 8, 4'b1110, 1, 1);
    add(0, 1, 4, 8, 4'b1110, 1, 1);

    n_reset   = 1'b0;
    enable    = 1'b1;
    direction = 1'b0;
    repeat (2) @(negedge clock);
    check_all("in_reset", 2, 4'b1111, 0, 0);
    n_reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      enable    = vecs[i].en;
      direction = vecs[i].dir;
      run(vecs[i].cycles);
      check_all($sformatf("row%0d", i), vecs[i].pos, vecs[i].sens, vecs[i].mov, vecs[i].flt);
    end

    // Asynchronous reset between clock edges while stalled at the top
    @(posedge clock);
    #2;
    n_reset = 1'b0;
    #1;
    check_all("async_reset", 2, 4'b1111, 0, 0);
    @(negedge clock);
    enable  = 1'b1;
    n_reset = 1'b1;
    run(3);
    check_all("after_reset", 2, 4'b1111, 0, 0);

    // Fresh run to the top: fault only on the first stalled step
    enable    = 1'b0;
    direction = 1'b1;
    run(1);
    check_all("top_entry", 2, 4'b1111, 1, 0);
    run(24);
    check_all("top_arrive", 8, 4'b1110, 1, 0);
    run(3);
    check_all("top_pre_stall", 8, 4'b1110, 1, 0);
    run(1);
    check_all("top_stall", 8, 4'b1110, 1, 1);
    enable = 1'b1;
    run(1);
    check_all("top_stop", 8, 4'b1110, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
